// File: rtl/model_read_heads_pkg.sv
// Shared types, default parameter values and the signed fixed-point multiply
// used by the read-heads array.
package model_read_heads_pkg;

  localparam int unsigned DEFAULT_DATA_SIZE       = 64;
  localparam int unsigned DEFAULT_CONTROL_SIZE    = 4;
  localparam int unsigned DEFAULT_FRACTIONAL_SIZE = 32;

  localparam int unsigned MUL_OPERAND_W = 64;
  localparam int unsigned MUL_PRODUCT_W = 2 * MUL_OPERAND_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  // Full-width signed product, arithmetic-shifted down by the fraction bits;
  // callers truncate to their own data width.
  function automatic logic signed [MUL_PRODUCT_W-1:0] fixed_mul(
    input logic signed [MUL_OPERAND_W-1:0] a,
    input logic signed [MUL_OPERAND_W-1:0] b,
    input int unsigned                     frac
  );
    logic signed [MUL_PRODUCT_W-1:0] p;
    p = MUL_PRODUCT_W'(a) * MUL_PRODUCT_W'(b);
    return p >>> frac;
  endfunction

endpackage

// File: rtl/model_read_heads_mac.sv
// Multiply-shift-accumulate datapath: acc += (W_IN*M_IN) >>> FRACTIONAL_SIZE,
// wrapping modulo 2^DATA_SIZE.
module model_read_heads_mac
  import model_read_heads_pkg::*;
#(
  parameter int unsigned DATA_SIZE       = DEFAULT_DATA_SIZE,
  parameter int unsigned FRACTIONAL_SIZE = DEFAULT_FRACTIONAL_SIZE
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [DATA_SIZE-1:0] W_IN,
  input  logic [DATA_SIZE-1:0] M_IN,
  output logic [DATA_SIZE-1:0] acc,
  output logic [DATA_SIZE-1:0] sum_c
);

  logic signed [MUL_PRODUCT_W-1:0] full_c;
  logic [DATA_SIZE-1:0]            product_c;

  always_comb begin
    full_c    = fixed_mul(MUL_OPERAND_W'($signed(W_IN)),
                          MUL_OPERAND_W'($signed(M_IN)), FRACTIONAL_SIZE);
    product_c = DATA_SIZE'(full_c);
    sum_c     = acc + product_c;
  end

  // Clear wins over enable so a new term never mixes with a stale sum.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= sum_c;
    end
  end

endmodule

// File: rtl/model_read_heads_array.sv
// Read heads: r[i][k] = sum_j w[i][j]*M[j][k], streamed in with a request /
// enable handshake and streamed out one element at a time with backpressure.
module model_read_heads_array
  import model_read_heads_pkg::*;
#(
  parameter int unsigned DATA_SIZE       = DEFAULT_DATA_SIZE,
  parameter int unsigned CONTROL_SIZE    = DEFAULT_CONTROL_SIZE,
  parameter int unsigned FRACTIONAL_SIZE = DEFAULT_FRACTIONAL_SIZE
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] SIZE_R_IN,
  input  logic [DATA_SIZE-1:0] SIZE_N_IN,
  input  logic [DATA_SIZE-1:0] SIZE_W_IN,
  output logic                 DATA_REQUEST,
  input  logic                 DATA_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] W_IN,
  input  logic [DATA_SIZE-1:0] M_IN,
  output logic [DATA_SIZE-1:0] INDEX_I_OUT,
  output logic [DATA_SIZE-1:0] INDEX_J_OUT,
  output logic [DATA_SIZE-1:0] INDEX_K_OUT,
  output logic [DATA_SIZE-1:0] R_OUT,
  output logic                 R_OUT_ENABLE,
  input  logic                 R_OUT_READY,
  output logic                 R_OUT_LAST_K,
  output logic                 R_OUT_LAST
);

  // Control width exists only so this block matches its siblings' parameter list.
  if (CONTROL_SIZE == 0) begin : g_control_unused
  end

  state_t               state;
  logic [DATA_SIZE-1:0] size_r;
  logic [DATA_SIZE-1:0] size_n;
  logic [DATA_SIZE-1:0] size_w;
  logic                 zero_run;

  logic                 handshake_c;
  logic                 accept_c;
  logic                 clear_c;
  logic                 j_last_c;
  logic                 k_last_c;
  logic                 i_last_c;
  logic                 any_zero_c;
  logic [DATA_SIZE-1:0] sum_c;
  logic [DATA_SIZE-1:0] acc;

  always_comb begin
    handshake_c = (state == FETCH) && DATA_REQUEST && DATA_IN_ENABLE;
    accept_c    = (state == OUTPUT) && R_OUT_READY;
    clear_c     = ((state == IDLE) && START) || accept_c;
    j_last_c    = INDEX_J_OUT == (size_n - DATA_SIZE'(1));
    k_last_c    = INDEX_K_OUT == (size_w - DATA_SIZE'(1));
    i_last_c    = INDEX_I_OUT == (size_r - DATA_SIZE'(1));
    any_zero_c  = (SIZE_R_IN == '0) || (SIZE_N_IN == '0) || (SIZE_W_IN == '0);
  end

  model_read_heads_mac #(
    .DATA_SIZE      (DATA_SIZE),
    .FRACTIONAL_SIZE(FRACTIONAL_SIZE)
  ) u_mac (
    .CLK   (CLK),
    .RST   (RST),
    .clear (clear_c),
    .enable(handshake_c),
    .W_IN  (W_IN),
    .M_IN  (M_IN),
    .acc   (acc),
    .sum_c (sum_c)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      READY        <= 1'b1;
      DATA_REQUEST <= 1'b0;
      INDEX_I_OUT  <= '0;
      INDEX_J_OUT  <= '0;
      INDEX_K_OUT  <= '0;
      R_OUT        <= '0;
      R_OUT_ENABLE <= 1'b0;
      R_OUT_LAST_K <= 1'b0;
      R_OUT_LAST   <= 1'b0;
      size_r       <= '0;
      size_n       <= '0;
      size_w       <= '0;
      zero_run     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            size_r       <= SIZE_R_IN;
            size_n       <= SIZE_N_IN;
            size_w       <= SIZE_W_IN;
            INDEX_I_OUT  <= '0;
            INDEX_J_OUT  <= '0;
            INDEX_K_OUT  <= '0;
            zero_run     <= any_zero_c;
            DATA_REQUEST <= !any_zero_c;
            READY        <= 1'b0;
            state        <= FETCH;
          end
        end
        FETCH: begin
          // An empty problem passes through here for one cycle only.
          if (zero_run) begin
            zero_run <= 1'b0;
            READY    <= 1'b1;
            state    <= IDLE;
          end else if (handshake_c) begin
            if (j_last_c) begin
              R_OUT        <= sum_c;
              R_OUT_ENABLE <= 1'b1;
              R_OUT_LAST_K <= k_last_c;
              R_OUT_LAST   <= k_last_c && i_last_c;
              DATA_REQUEST <= 1'b0;
              state        <= OUTPUT;
            end else begin
              INDEX_J_OUT <= INDEX_J_OUT + DATA_SIZE'(1);
            end
          end
        end
        OUTPUT: begin
          if (R_OUT_READY) begin
            R_OUT_ENABLE <= 1'b0;
            R_OUT_LAST_K <= 1'b0;
            R_OUT_LAST   <= 1'b0;
            INDEX_J_OUT  <= '0;
            if (k_last_c) begin
              INDEX_K_OUT <= '0;
              INDEX_I_OUT <= INDEX_I_OUT + DATA_SIZE'(1);
            end else begin
              INDEX_K_OUT <= INDEX_K_OUT + DATA_SIZE'(1);
            end
            if (k_last_c && i_last_c) begin
              READY <= 1'b1;
              state <= IDLE;
            end else begin
              DATA_REQUEST <= 1'b1;
              state        <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_model_read_heads_array.sv
// Bench for model_read_heads_array: two instances (0 and 8 fraction bits) share
// stimulus; results are checked against a plain-arithmetic matrix product.
module tb_model_read_heads_array;

  localparam int unsigned DS = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DS-1:0] size_r = '0, size_n = '0, size_w = '0;
  logic          din_en = 1'b0;
  logic [DS-1:0] w_in = '0, m_in = '0;
  logic          rout_ready = 1'b0;

  logic          ready0, dreq0, rout_en0, rlk0, rl0;
  logic [DS-1:0] idx_i0, idx_j0, idx_k0, rout0;
  logic          ready8, dreq8, rout_en8, rlk8, rl8;
  logic [DS-1:0] idx_i8, idx_j8, idx_k8, rout8;

  int unsigned pass_cnt = 0;
  int unsigned check_cnt = 0;
  logic [DS-1:0] wv[4][4];
  logic [DS-1:0] mv[4][4];
  logic [DS-1:0] got0[$];
  logic [DS-1:0] got8[$];
  int cyc_used;

  always #5 clk = ~clk;

  model_read_heads_array #(.DATA_SIZE(DS), .CONTROL_SIZE(4), .FRACTIONAL_SIZE(0)) dut0 (
    .CLK(clk), .RST(rst), .START(start), .READY(ready0),
    .SIZE_R_IN(size_r), .SIZE_N_IN(size_n), .SIZE_W_IN(size_w),
    .DATA_REQUEST(dreq0), .DATA_IN_ENABLE(din_en), .W_IN(w_in), .M_IN(m_in),
    .INDEX_I_OUT(idx_i0), .INDEX_J_OUT(idx_j0), .INDEX_K_OUT(idx_k0),
    .R_OUT(rout0), .R_OUT_ENABLE(rout_en0), .R_OUT_READY(rout_ready),
    .R_OUT_LAST_K(rlk0), .R_OUT_LAST(rl0)
  );

  model_read_heads_array #(.DATA_SIZE(DS), .CONTROL_SIZE(4), .FRACTIONAL_SIZE(8)) dut8 (
    .CLK(clk), .RST(rst), .START(start), .READY(ready8),
    .SIZE_R_IN(size_r), .SIZE_N_IN(size_n), .SIZE_W_IN(size_w),
    .DATA_REQUEST(dreq8), .DATA_IN_ENABLE(din_en), .W_IN(w_in), .M_IN(m_in),
    .INDEX_I_OUT(idx_i8), .INDEX_J_OUT(idx_j8), .INDEX_K_OUT(idx_k8),
    .R_OUT(rout8), .R_OUT_ENABLE(rout_en8), .R_OUT_READY(rout_ready),
    .R_OUT_LAST_K(rlk8), .R_OUT_LAST(rl8)
  );

  // Reference: fixed-point dot product of row i of w with column k of M.
  function automatic logic [DS-1:0] model_r(input int i, input int k, input int n, input int frac);
    longint acc;
    longint p;
    acc = 0;
    for (int j = 0; j < n; j++) begin
      p = longint'(shortint'(wv[i][j])) * longint'(shortint'(mv[j][k]));
      acc += p >>> frac;
    end
    return DS'(acc);
  endfunction

  // Runs one full operation, checking every output and index it sees.
  task automatic run_op(input int r, input int n, input int wd, input bit rnd, input int hold);
    int ei = 0, ek = 0, ej = 0, held = 0, cyc = 0;
    bit done = 1'b0;
    logic [DS-1:0] e0, e8;
    bit exp_lk, exp_l;
    got0.delete();
    got8.delete();
    size_r = DS'(r); size_n = DS'(n); size_w = DS'(wd);
    din_en = 1'b0; rout_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!done && cyc < 3000) begin
      if (rout_en0) begin
        e0 = model_r(ei, ek, n, 0);
        e8 = model_r(ei, ek, n, 8);
        exp_lk = (ek == wd - 1);
        exp_l  = exp_lk && (ei == r - 1);
        check_cnt++;
        if (rout0 !== e0) $display("FAIL r_out_frac0 i=%0d k=%0d got=%h exp=%h", ei, ek, rout0, e0);
        else pass_cnt++;
        check_cnt++;
        if (rout8 !== e8) $display("FAIL r_out_frac8 i=%0d k=%0d got=%h exp=%h", ei, ek, rout8, e8);
        else pass_cnt++;
        check_cnt++;
        if (rlk0 !== exp_lk || rl0 !== exp_l || rlk8 !== exp_lk || rl8 !== exp_l)
          $display("FAIL last_flags i=%0d k=%0d got=%b%b/%b%b exp=%b%b", ei, ek, rlk0, rl0, rlk8, rl8, exp_lk, exp_l);
        else pass_cnt++;
        check_cnt++;
        if (dreq0 !== 1'b0 || dreq8 !== 1'b0 || rout_en8 !== 1'b1)
          $display("FAIL output_flow got dreq=%b/%b en8=%b exp dreq=0 en8=1", dreq0, dreq8, rout_en8);
        else pass_cnt++;
        check_cnt++;
        if (idx_i0 !== DS'(ei) || idx_k0 !== DS'(ek))
          $display("FAIL out_index got i=%0d k=%0d exp i=%0d k=%0d", idx_i0, idx_k0, ei, ek);
        else pass_cnt++;
        din_en = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        w_in = DS'($urandom); m_in = DS'($urandom);
        if (held < hold) begin
          rout_ready = 1'b0;
          held++;
        end else begin
          rout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (rout_ready) begin
          got0.push_back(rout0);
          got8.push_back(rout8);
          held = 0;
          if (ek == wd - 1) begin
            ek = 0;
            if (ei == r - 1) done = 1'b1;
            ei++;
          end else begin
            ek++;
          end
        end
      end else if (dreq0) begin
        check_cnt++;
        if (idx_i0 !== DS'(ei) || idx_j0 !== DS'(ej) || idx_k0 !== DS'(ek) ||
            idx_i8 !== DS'(ei) || idx_j8 !== DS'(ej) || idx_k8 !== DS'(ek) ||
            rlk0 !== 1'b0 || rl0 !== 1'b0)
          $display("FAIL fetch_index got i=%0d j=%0d k=%0d lk=%b l=%b exp i=%0d j=%0d k=%0d lk=0 l=0",
                   idx_i0, idx_j0, idx_k0, rlk0, rl0, ei, ej, ek);
        else pass_cnt++;
        rout_ready = rnd ? 1'($urandom_range(0, 1)) : (hold == 0);
        din_en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (din_en) begin
          w_in = wv[ei][ej];
          m_in = mv[ej][ek];
          ej = (ej == n - 1) ? 0 : ej + 1;
        end else begin
          w_in = DS'($urandom); m_in = DS'($urandom);
        end
      end else begin
        check_cnt++;
        $display("FAIL stalled got dreq=0 r_out_enable=0 exp one of them high");
        done = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    din_en = 1'b0;
    rout_ready = 1'b0;
    check_cnt++;
    if (!done) $display("FAIL op_timeout got cycles=%0d exp completion", cyc);
    else pass_cnt++;
    check_cnt++;
    if (ready0 !== 1'b1 || ready8 !== 1'b1 || rout_en0 !== 1'b0 || dreq0 !== 1'b0)
      $display("FAIL after_op got ready=%b/%b en=%b dreq=%b exp ready=1 en=0 dreq=0", ready0, ready8, rout_en0, dreq0);
    else pass_cnt++;
    check_cnt++;
    if (got0.size() != r * wd) $display("FAIL out_count got=%0d exp=%0d", got0.size(), r * wd);
    else pass_cnt++;
    cyc_used = cyc;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    check_cnt++;
    if (ready0 !== 1'b1 || dreq0 !== 1'b0 || rout_en0 !== 1'b0 || rout0 !== '0 ||
        idx_i0 !== '0 || idx_j0 !== '0 || idx_k0 !== '0 || rlk0 !== 1'b0 || rl0 !== 1'b0)
      $display("FAIL reset_state got ready=%b dreq=%b en=%b r=%h i=%0d j=%0d k=%0d lk=%b l=%b exp ready=1 rest 0",
               ready0, dreq0, rout_en0, rout0, idx_i0, idx_j0, idx_k0, rlk0, rl0);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic load_basic();
    wv[0][0] = 16'd1; wv[0][1] = 16'd2;
    mv[0][0] = 16'd3; mv[0][1] = 16'd4;
    mv[1][0] = 16'd5; mv[1][1] = 16'd6;
  endtask

  task automatic test_basic();
    load_basic();
    run_op(1, 2, 2, 1'b0, 0);
    check_cnt++;
    if (got0.size() != 2 || got0[0] !== 16'd13 || got0[1] !== 16'd16)
      $display("FAIL basic_values got n=%0d first=%0d exp 13 then 16", got0.size(), got0.size() > 0 ? got0[0] : 16'd0);
    else pass_cnt++;
    check_cnt++;
    if (cyc_used != 6) $display("FAIL basic_latency got=%0d exp=6", cyc_used);
    else pass_cnt++;
  endtask

  task automatic test_negative();
    wv[0][0] = 16'd2; wv[1][0] = 16'hFFFD; mv[0][0] = 16'd7;
    run_op(2, 1, 1, 1'b0, 0);
    check_cnt++;
    if (got0.size() != 2 || got0[0] !== 16'h000E || got0[1] !== 16'hFFEB)
      $display("FAIL negative_values got n=%0d exp 000e then ffeb", got0.size());
    else pass_cnt++;
  endtask

  task automatic test_hold();
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        wv[a][b] = DS'($urandom);
        mv[a][b] = DS'($urandom);
      end
    run_op(1, 2, 1, 1'b0, 5);
    check_cnt++;
    if (got0.size() != 1 || got0[0] !== model_r(0, 0, 2, 0))
      $display("FAIL hold_value got n=%0d exp one element", got0.size());
    else pass_cnt++;
  endtask

  task automatic test_zero_size();
    int low = 0;
    bit seen = 1'b0;
    size_r = 16'd1; size_n = 16'd0; size_w = 16'd1;
    din_en = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (!ready0) low++;
      if (dreq0 || rout_en0 || dreq8 || rout_en8) seen = 1'b1;
      @(posedge clk); #1;
    end
    din_en = 1'b0;
    check_cnt++;
    if (low != 1) $display("FAIL zero_ready_low got=%0d exp=1", low);
    else pass_cnt++;
    check_cnt++;
    if (seen) $display("FAIL zero_no_activity got activity=1 exp=0");
    else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    load_basic();
    size_r = 16'd1; size_n = 16'd4; size_w = 16'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    din_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cnt++;
    if (idx_j0 !== 16'd3 || dreq0 !== 1'b1) $display("FAIL midop_progress got j=%0d dreq=%b exp j=3 dreq=1", idx_j0, dreq0);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    check_cnt++;
    if (ready0 !== 1'b1 || dreq0 !== 1'b0 || rout_en0 !== 1'b0 || rout0 !== '0 ||
        idx_i0 !== '0 || idx_j0 !== '0 || idx_k0 !== '0 || rlk0 !== 1'b0 || rl0 !== 1'b0)
      $display("FAIL midop_reset got ready=%b dreq=%b en=%b j=%0d exp ready=1 rest 0", ready0, dreq0, rout_en0, idx_j0);
    else pass_cnt++;
    #1 rst = 1'b0;
    din_en = 1'b0;
    @(posedge clk); #1;
    run_op(1, 2, 2, 1'b0, 0);
    check_cnt++;
    if (got0.size() != 2 || got0[0] !== 16'd13 || got0[1] !== 16'd16)
      $display("FAIL rerun_values got n=%0d exp 13 then 16", got0.size());
    else pass_cnt++;
  endtask

  task automatic test_fixed_point();
    wv[0][0] = 16'h0180; mv[0][0] = 16'h0200;
    run_op(1, 1, 1, 1'b0, 0);
    check_cnt++;
    if (got8.size() != 1 || got8[0] !== 16'h0300) $display("FAIL frac8_value got=%h exp=0300", got8.size() > 0 ? got8[0] : 16'hXXXX);
    else pass_cnt++;
    wv[0][0] = 16'd1; wv[0][1] = 16'd1; mv[0][0] = 16'h7FFF; mv[1][0] = 16'd1;
    run_op(1, 2, 1, 1'b0, 0);
    check_cnt++;
    if (got0.size() != 1 || got0[0] !== 16'h8000) $display("FAIL wrap_value got=%h exp=8000", got0.size() > 0 ? got0[0] : 16'hXXXX);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        wv[a][b] = DS'($urandom);
        mv[a][b] = DS'($urandom);
      end
    run_op(2, 3, 2, 1'b0, 0);
    check_cnt++;
    if (cyc_used != 16) $display("FAIL back_to_back_cycles got=%0d exp=16", cyc_used);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++) begin
          wv[a][b] = DS'($urandom);
          mv[a][b] = DS'($urandom);
        end
      run_op(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 1'b1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_hold();
    test_zero_size();
    test_reset_midop();
    test_fixed_point();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/model_read_heads_array.md
MODEL_READ_HEADS_ARRAY -- requirements
Module: model_read_heads_array

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, meaning the data word and size-operand width.
REQ-002 SHALL have parameter CONTROL_SIZE, default 4, meaning the control width kept for family compatibility (unused internally).
REQ-003 SHALL have parameter FRACTIONAL_SIZE, default 32, meaning the number of fraction bits in the signed fixed-point format.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: CLK  in  1  clock; RST  in  1  asynchronous active-high reset.
REQ-005 SHALL have START  in  1  request to begin a read of all heads.
REQ-006 SHALL have READY  out  1  high while idle, low while busy.
REQ-007 SHALL have SIZE_R_IN, SIZE_N_IN, SIZE_W_IN  in  DATA_SIZE each  head count, memory rows and word width.
REQ-008 SHALL have DATA_REQUEST  out  1  held high while awaiting w[i][j] and M[j][k].
REQ-009 SHALL have DATA_IN_ENABLE  in  1  W_IN and M_IN valid this cycle.
REQ-010 SHALL have W_IN, M_IN  in  DATA_SIZE each  weighting element and memory element.
REQ-011 SHALL have INDEX_I_OUT, INDEX_J_OUT, INDEX_K_OUT  out  DATA_SIZE each  current head, row and column.
REQ-012 SHALL have R_OUT  out  DATA_SIZE  read-vector element r[i][k].
REQ-013 SHALL have R_OUT_ENABLE  out  1  R_OUT valid, held until accepted.
REQ-014 SHALL have R_OUT_READY  in  1  consumer accepts R_OUT.
REQ-015 SHALL have R_OUT_LAST_K  out  1  and R_OUT_LAST  out  1, qualifying the last element of a head and of the whole operation.

Function
REQ-016 SHALL compute r[i][k] = sum over j of w[i][j]*M[j][k], for i<SIZE_R, k<SIZE_W, j<SIZE_N.
REQ-017 SHALL iterate with i outermost, k middle and j innermost.
REQ-018 SHALL implement FSM states IDLE, FETCH and OUTPUT.
REQ-019 SHALL latch the sizes on START in IDLE, clear the accumulator and all indices, and go to FETCH; START in any other state SHALL be ignored.
REQ-020 SHALL, when START sees any size equal to 0, go to a one-cycle pass through FETCH with DATA_REQUEST low and then return to IDLE, so READY is low for exactly one cycle and no outputs are produced.
REQ-021 SHALL, in FETCH, consume a handshake only on a cycle where DATA_REQUEST and DATA_IN_ENABLE are both high; DATA_IN_ENABLE at any other time SHALL be ignored.
REQ-022 SHALL form each product as a signed 2*DATA_SIZE result, arithmetic-shifted right by FRACTIONAL_SIZE and truncated to DATA_SIZE bits.
REQ-023 SHALL accumulate modulo 2^DATA_SIZE, with no saturation.
REQ-024 SHALL increment j on each handshake while j<SIZE_N-1.
REQ-025 SHALL, on the handshake with j=SIZE_N-1, register acc+product into R_OUT and go to OUTPUT on the next cycle.
REQ-026 SHALL, in OUTPUT, hold R_OUT_ENABLE, R_OUT and the flags stable until R_OUT_READY is high; DATA_REQUEST SHALL stay low during OUTPUT.
REQ-027 SHALL, on acceptance, clear the accumulator and j, then advance k, wrapping to 0 and incrementing i at k=SIZE_W-1.
REQ-028 SHALL return to IDLE after acceptance of i=SIZE_R-1, k=SIZE_W-1, with READY high the following cycle.
REQ-029 SHALL assert R_OUT_LAST_K when k=SIZE_W-1, and R_OUT_LAST when additionally i=SIZE_R-1; both SHALL be low outside OUTPUT.
REQ-030 SHALL drive INDEX_*_OUT as registered copies of the current i, j, k at all times.
REQ-031 SHALL sustain one handshake per cycle in FETCH and accept an output with zero idle cycles when R_OUT_READY is already high.

Reset
REQ-032 SHALL, on RST assertion at any time including mid-operation, immediately force state IDLE, READY=1 and all other outputs to 0, and clear the accumulator, indices and latched sizes.
REQ-033 SHALL accept START on the first rising CLK edge after RST deasserts.

Structure
REQ-034 SHALL place the FSM state enum, the default parameter values and a fixed-point multiply function in package model_read_heads_pkg.
REQ-035 SHALL place the multiply-shift-accumulate datapath in sub-module model_read_heads_mac, with inputs clear, enable, W_IN, M_IN and output acc.

Verification
REQ-036 SHALL cover, with DATA_SIZE=16, FRACTIONAL_SIZE=0, R=1, N=2, W=2, w=[1,2], M=[[3,4],[5,6]] -> R_OUT 13 then 16, INDEX_K_OUT 0 then 1, R_OUT_LAST on 16, READY high afterwards.
REQ-037 SHALL cover R=2, N=1, W=1, w=[2],[-3], M=7 -> R_OUT 0x000E then 0xFFEB, with R_OUT_LAST_K on both and R_OUT_LAST only on the second.
REQ-038 SHALL cover R_OUT_READY held low for 5 cycles -> R_OUT and the flags stable, DATA_REQUEST low, and exactly one output counted after release.
REQ-039 SHALL cover START with SIZE_N_IN=0 -> READY low for exactly one cycle, and DATA_REQUEST and R_OUT_ENABLE never asserted.
REQ-040 SHALL cover RST pulsed after 3 handshakes -> all outputs at reset values in the same cycle, and a rerun of REQ-036 reproduces 13 and 16.
REQ-041 SHALL cover FRACTIONAL_SIZE=8, w=0x0180, M=0x0200 -> 0x0300, and, with FRACTIONAL_SIZE=0, N=2, w=[1,1], M=[0x7FFF,1] -> 0x8000 (wrap).
